// File: rtl/fp8_dot_seq_pkg.sv
// Shared E5M2/FP32 field constants, lane classification helpers and the
// sequencer state type for the FP8 dot-product sequencer.
package fp8_dot_seq_pkg;

    localparam int          EXP_MSB   = 6;
    localparam int          EXP_LSB   = 2;
    localparam int          MAN_W     = 2;
    localparam logic [4:0]  EXP_ALL1  = 5'b11111;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic zero;     // magnitude bits all zero (+0 / -0)
        logic special;  // Inf or NaN
    } e5m2_class_t;

    function automatic e5m2_class_t is_e5m2_zero_or_special(input logic [7:0] x);
        e5m2_class_t c;
        c.zero    = (x[6:0] == 7'd0);
        c.special = (x[EXP_MSB:EXP_LSB] == EXP_ALL1);
        return c;
    endfunction

    // A zero product only drops out when neither side could turn it into a NaN.
    function automatic logic lane_skippable(input logic [7:0] a, input logic [7:0] b);
        e5m2_class_t ca;
        e5m2_class_t cb;
        ca = is_e5m2_zero_or_special(a);
        cb = is_e5m2_zero_or_special(b);
        return (ca.zero || cb.zero) && !ca.special && !cb.special;
    endfunction

endpackage

// File: rtl/fp8_dot_seq.sv
// Walks the K E5M2 lanes of a vector pair, issuing one external MAC per
// non-trivial lane and chaining each FP32 result into the next issue.
module fp8_dot_seq
    import fp8_dot_seq_pkg::*;
#(
    parameter int RLEN = 128,
    parameter int IDXW = $clog2(RLEN/8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RLEN-1:0] in_a,
    input  logic [RLEN-1:0] in_b,
    input  logic [31:0]     in_acc,
    output logic            mac_valid,
    output logic [7:0]      mac_a,
    output logic [7:0]      mac_b,
    output logic [31:0]     mac_acc,
    input  logic            mac_out_valid,
    input  logic [31:0]     mac_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            busy
);

    localparam int K = RLEN / 8;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [RLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [31:0]       acc_q, acc_d;
    logic              mac_valid_q, mac_valid_d;
    logic [7:0]        mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [31:0]       mac_acc_q, mac_acc_d;

    logic [7:0]        lane_a, lane_b;
    logic              last_lane;

    assign lane_a    = a_q[{idx_q, 3'b000} +: 8];
    assign lane_b    = b_q[{idx_q, 3'b000} +: 8];
    assign last_lane = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mac_valid_d = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_acc_d   = mac_acc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = in_acc;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (lane_skippable(lane_a, lane_b)) begin
                    if (last_lane) state_d = ST_DONE;
                    else           idx_d   = idx_q + 1'b1;
                end else begin
                    mac_valid_d = 1'b1;
                    mac_a_d     = lane_a;
                    mac_b_d     = lane_b;
                    mac_acc_d   = acc_q;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Results arriving in any other state are stale and dropped.
                if (mac_out_valid) begin
                    acc_d = mac_result;
                    if (last_lane) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= FP32_ZERO;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_acc_q   <= FP32_ZERO;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mac_valid_q <= mac_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_acc_q   <= mac_acc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign mac_valid = mac_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_acc   = mac_acc_q;

endmodule

// File: tb/tb_fp8_dot_seq.sv
// Bench for fp8_dot_seq: behavioural FP MAC stand-in plus a lane-by-lane
// reference of the dot-product issue order and final accumulator.
module tb_fp8_dot_seq;
    import fp8_dot_seq_pkg::*;

    localparam int RLEN = 128;
    localparam int K    = RLEN / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [RLEN-1:0] in_a, in_b;
    logic [31:0]     in_acc;
    logic            mac_valid;
    logic [7:0]      mac_a, mac_b;
    logic [31:0]     mac_acc;
    logic            mac_out_valid;
    logic [31:0]     mac_result;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            busy;

    fp8_dot_seq #(.RLEN(RLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .mac_out_valid(mac_out_valid), .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- FP helpers (plain real arithmetic) ----------------
    function automatic real e5m2_to_real(input logic [7:0] x);
        int  e;
        real m, r;
        e = int'(x[6:2]);
        m = real'(x[1:0]);
        if (e == 0) r = (m / 4.0) * (2.0 ** (-14));
        else        r = (1.0 + m / 4.0) * (2.0 ** (e - 15));
        return x[7] ? -r : r;
    endfunction

    function automatic real fp32_to_real(input logic [31:0] x);
        int  e;
        real f, r;
        e = int'(x[30:23]);
        f = real'(x[22:0]);
        if (e == 0) r = f * (2.0 ** (-149));
        else        r = (1.0 + f / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic s;
        real  m;
        int   e;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m <  1.0) begin m = m * 2.0; e--; end
        if (e + 127 <= 0)   return {s, 31'h0};
        if (e + 127 >= 255) return {s, 8'hFF, 23'h0};
        return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] mac_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [31:0] acc);
        if (a[6:2] == 5'h1F || b[6:2] == 5'h1F || acc[30:23] == 8'hFF) return 32'h7FC0_0000;
        return real_to_fp32(e5m2_to_real(a) * e5m2_to_real(b) + fp32_to_real(acc));
    endfunction

    // ---------------- external MAC stand-in ----------------
    logic [47:0] issue_q[$];
    int mac_lat  = 1;     // 255 = never answer
    int dbl_cnt  = 0;     // mac_valid seen high on consecutive cycles
    int inj_cnt  = 0, kill_cnt = 0;

    initial begin
        int inj_done = 0, kill_done = 0, cnt = 0;
        logic pend = 1'b0, prev_mv = 1'b0;
        logic [31:0] res = '0;
        mac_out_valid = 1'b0;
        mac_result    = '0;
        forever begin
            @(negedge clk);
            mac_out_valid = 1'b0;
            if (kill_cnt != kill_done) begin pend = 1'b0; kill_done = kill_cnt; end
            if (inj_cnt != inj_done) begin
                mac_out_valid = 1'b1;
                mac_result    = 32'hDEAD_BEEF;
                inj_done      = inj_cnt;
            end
            if (mac_valid === 1'b1) begin
                issue_q.push_back({mac_a, mac_b, mac_acc});
                if (prev_mv) dbl_cnt++;
                pend = 1'b1;
                cnt  = mac_lat;
                res  = mac_fn(mac_a, mac_b, mac_acc);
            end
            prev_mv = (mac_valid === 1'b1);
            if (pend && mac_lat != 255) begin
                if (cnt == 0) begin
                    mac_out_valid = 1'b1;
                    mac_result    = res;
                    pend          = 1'b0;
                end else cnt--;
            end
        end
    end

    // ---------------- one full transaction vs. reference ----------------
    task automatic run_vec(input string tag, input logic [RLEN-1:0] a, input logic [RLEN-1:0] b,
                           input logic [31:0] acc, input int hold);
        logic [47:0] exp_q[$];
        logic [31:0] acc_m;
        logic [7:0]  la, lb;
        logic        skip;
        int          cyc;

        acc_m = acc;
        for (int i = 0; i < K; i++) begin
            la   = a[8*i +: 8];
            lb   = b[8*i +: 8];
            skip = (la[6:0] == 7'd0 || lb[6:0] == 7'd0) && la[6:2] != 5'h1F && lb[6:2] != 5'h1F;
            if (!skip) begin
                exp_q.push_back({la, lb, acc_m});
                acc_m = mac_fn(la, lb, acc_m);
            end
        end

        issue_q.delete();
        @(negedge clk);
        in_a = a; in_b = b; in_acc = acc; in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk({tag, " accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) in_valid = 1'b0;
        end while (!out_valid && cyc < 5000);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        if (exp_q.size() == 0) chk({tag, " latency"}, 64'(cyc), 64'(K + 1));

        for (int h = 0; h < hold; h++) begin
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold data"}, 64'(out_data), 64'(acc_m));
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk({tag, " out_data"}, 64'(out_data), 64'(acc_m));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " post in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " post out_valid"}, 64'(out_valid), 64'd0);

        chk({tag, " issues"}, 64'(issue_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issue_q.size(); i++)
            chk({tag, " issue"}, 64'(issue_q[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [7:0] rand_e5m2();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'($urandom);
            default: return {1'($urandom), 5'($urandom_range(10, 20)), 2'($urandom)};
        endcase
    endfunction

    initial begin
        logic [RLEN-1:0] va, vb;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst mac_valid", 64'(mac_valid), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst mac_fields", 64'({mac_a, mac_b, mac_acc}), 64'd0);
        rst = 1'b0;

        va = '0; vb = '0; va[7:0] = 8'h3E; vb[7:0] = 8'h3E;
        run_vec("lane0", va, vb, 32'h3E80_0000, 0);
        chk("lane0 result", 64'(out_data), 64'h4020_0000);

        va = {K{8'h3C}}; vb = {K{8'h3C}};
        run_vec("ones", va, vb, FP32_ZERO, 0);
        chk("ones result", 64'(out_data), 64'h4180_0000);
        if (issue_q.size() == K) chk("ones last acc", 64'(issue_q[K-1][31:0]), 64'h4170_0000);
        chk("mac_valid single", 64'(dbl_cnt), 64'd0);

        run_vec("zeros", '0, '0, FP32_ONE, 0);

        va = '0; vb = '0; va[47:40] = 8'h7E;
        run_vec("nan5", va, vb, FP32_ONE, 0);
        if (issue_q.size() == 1) chk("nan5 ops", 64'(issue_q[0][47:32]), 64'h7E00);

        va = '0; vb = '0; va[23:16] = 8'h40; vb[23:16] = 8'h3C;
        run_vec("hold", va, vb, FP32_ONE, 10);

        // reset while waiting on the MAC, then a stale result
        mac_lat = 255;
        @(negedge clk);
        in_a = {K{8'h3C}}; in_b = {K{8'h3C}}; in_acc = FP32_ONE; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        kill_cnt++;
        chk("mid rst in_ready", 64'(in_ready), 64'd1);
        chk("mid rst out_valid", 64'(out_valid), 64'd0);
        chk("mid rst mac_valid", 64'(mac_valid), 64'd0);
        chk("mid rst mac_acc", 64'(mac_acc), 64'd0);
        rst = 1'b0;
        inj_cnt++;
        repeat (3) @(negedge clk);
        chk("stale busy", 64'(busy), 64'd0);
        chk("stale in_ready", 64'(in_ready), 64'd1);
        chk("stale out_valid", 64'(out_valid), 64'd0);
        mac_lat = 2;
        va = '0; vb = '0; va[7:0] = 8'h3E; vb[7:0] = 8'h3E;
        run_vec("after rst", va, vb, 32'h3E80_0000, 0);
        chk("after rst result", 64'(out_data), 64'h4020_0000);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < K; i++) begin
                va[8*i +: 8] = rand_e5m2();
                vb[8*i +: 8] = rand_e5m2();
            end
            mac_lat = $urandom_range(0, 3);
            run_vec("rand", va, vb, real_to_fp32(real'($urandom_range(0, 64)) / 8.0),
                    $urandom_range(0, 2));
        end
        chk("mac_valid single end", 64'(dbl_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp8_dot_seq.md
Name: fp8_dot_seq

Overview:
- Upstream sequencer for the FP8 (E5M2) multiply-accumulate stage; also consumes that stage's FP32 result.
- Accepts one vector pair of RLEN bits each (K = RLEN/8 E5M2 lanes) plus an FP32 starting accumulator.
- Issues one MAC per non-trivial lane, feeding each MAC result back as the next accumulator.
- Returns the final FP32 dot-product over a valid/ready interface.

Parameters:
RLEN, 128, vector width in bits; K = RLEN/8 lanes, RLEN must be a multiple of 8
IDXW, $clog2(RLEN/8), lane index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  vector pair and accumulator present
in_ready  out  1  block can accept (IDLE only)
in_a  in  RLEN  operand A lanes; lane i = bits [8i+7:8i]
in_b  in  RLEN  operand B lanes, same packing
in_acc  in  32  FP32 starting accumulator
mac_valid  out  1  single-cycle issue strobe to the MAC stage
mac_a  out  8  E5M2 operand A for the issued lane
mac_b  out  8  E5M2 operand B for the issued lane
mac_acc  out  32  FP32 accumulator for the issued MAC
mac_out_valid  in  1  MAC result valid
mac_result  in  32  FP32 MAC result
out_valid  out  1  final result valid
out_ready  in  1  consumer accepts result
out_data  out  32  final FP32 accumulator
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, busy=0, mac_valid=0, out_valid=0. mac_a, mac_b, mac_acc and out_data reset to 0.
- FSM states: IDLE, SCAN, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_a, in_b and in_acc; set idx=0; go to SCAN.
- SCAN (examines lane idx, one lane per cycle):
  - A lane is skippable when a[6:0]==0 or b[6:0]==0, AND neither operand has exponent bits [6:2]==5'b11111. Inf or NaN is never skipped.
  - Skippable and idx<K-1: increment idx, stay in SCAN.
  - Skippable and idx==K-1: go to DONE.
  - Not skippable: assert mac_valid for exactly one cycle, with mac_a, mac_b and mac_acc (the current accumulator); go to WAIT.
- WAIT:
  - mac_valid=0; outputs mac_a, mac_b and mac_acc hold their values.
  - On mac_out_valid: accumulator <= mac_result. If idx==K-1 go to DONE, else increment idx and go to SCAN.
  - The MAC latency is arbitrary; the block waits indefinitely.
- DONE:
  - out_valid=1 and out_data=accumulator, both held stable until out_ready.
  - On out_valid && out_ready: go to IDLE. in_ready rises in the next cycle; no back-to-back bypass.
- mac_out_valid outside WAIT is ignored. This covers stale results after reset.
- Accumulator is stored bit-exact. The block does no arithmetic; all FP math belongs to the MAC stage.
- Timing, with acceptance at edge t:
  - All lanes skipped: out_valid high from t+K+1.
  - Each issued lane adds 1 (issue) + MAC latency cycles in place of its 1 skip cycle.
- rst mid-operation: return to IDLE immediately and discard captured data and accumulator; out_valid and mac_valid drop in the same cycle.
- in_valid while busy: not accepted (in_ready=0); the upstream holds the data.
- out_ready held high early has no effect until DONE.

Decomposition:
- Shared package holds:
  - E5M2 field constants: EXP_MSB=6, EXP_LSB=2, MAN_W=2, EXP_ALL1=5'b11111.
  - FP32 constants: FP32_ZERO=32'h0, FP32_ONE=32'h3F800000.
  - Function is_e5m2_zero_or_special.
  - State enum type.
- No sub-module. The MAC stage stays external and the testbench instantiates both.
- A lane-mux / skip-detect helper may live as a package function.

Test Plan:
- Lane 0: a=b=8'h3E (1.5), all other lanes 0, in_acc=32'h3E800000 -> exactly one mac_valid with mac_a=mac_b=8'h3E and mac_acc=32'h3E800000; out_data=32'h40200000.
- All lanes a=b=8'h3C (1.0), in_acc=0 -> 16 mac_valid pulses; out_data=32'h41800000 (16.0); mac_acc sequence is 0, 1.0, 2.0 … 15.0.
- All lanes zero, in_acc=32'h3F800000 -> no mac_valid; out_valid exactly K+1=17 cycles after acceptance; out_data=32'h3F800000.
- Lane 5: a=8'h7E (NaN), b=8'h00 -> lane not skipped; one MAC is issued carrying those operands.
- out_ready held low for 10 cycles in DONE -> out_valid and out_data stable and in_ready=0 throughout; IDLE and in_ready=1 follow the handshake.
- rst asserted in WAIT, then a late mac_out_valid -> state IDLE, out_valid=0, the late result is ignored, and the next vector computes correctly.
